// File: rtl/mbp_update_queue.sv
// In-order queue between the fetch-side prediction path and the mbp predictor update port.
// Optional MBP_UQ_STATS_EN adds saturating update/mispredict counters.
`timescale 1ns/1ps

package mbp_uq_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned GIdxW;
    int unsigned LIdxW;
  } cva6_cfg_t;

  localparam cva6_cfg_t build_config = '{VLEN: 64, GIdxW: 10, LIdxW: 8};

  typedef struct packed {
    logic [build_config.GIdxW-1:0] gindex;
    logic [1:0]                    gbp_cnt;
    logic                          gbp_taken;
    logic [build_config.LIdxW-1:0] lindex;
    logic [1:0]                    lbp_cnt;
    logic                          lbp_taken;
  } bp_metadata_t;

  typedef struct packed {
    logic                         valid;
    logic [build_config.VLEN-1:0] pc;
    logic                         taken;
    bp_metadata_t                 metadata;
  } bht_update_t;

endpackage

module mbp_update_queue #(
  parameter mbp_uq_pkg::cva6_cfg_t CVA6Cfg = mbp_uq_pkg::build_config,
  parameter type bp_metadata_t = mbp_uq_pkg::bp_metadata_t,
  parameter type bht_update_t = mbp_uq_pkg::bht_update_t,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  // push side: a beat transfers when push_valid_i && push_ready_o at the rising edge;
  // push_ready_o depends only on registered state, and a refused source holds its data.
  input  logic                      push_valid_i,
  output logic                      push_ready_o,
  input  logic [CVA6Cfg.VLEN-1:0]   push_pc_i,
  input  logic                      push_taken_i,
  input  bp_metadata_t              push_metadata_i,
  input  logic                      resolve_valid_i,
  input  logic                      resolve_taken_i,
  output bht_update_t               bht_update_o,
  output logic                      mispredict_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [CNT_W-1:0]          stat_updates_o,
  output logic [CNT_W-1:0]          stat_mispredicts_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [CVA6Cfg.VLEN-1:0] pc_q    [DEPTH];
  logic                    taken_q [DEPTH];
  bp_metadata_t            meta_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  bht_update_t      upd_q;
  logic             mis_q;

  logic do_push, do_pop;

  assign empty_o      = (occ_q == '0);
  assign full_o       = (occ_q == OCC_W'(DEPTH));
  assign push_ready_o = !full_o;
  assign occupancy_o  = occ_q;
  assign bht_update_o = upd_q;
  assign mispredict_o = mis_q;

  // A push coinciding with a flush is dropped; a resolve in the flush cycle still pops.
  assign do_push = push_valid_i && push_ready_o && !flush_i;
  assign do_pop  = resolve_valid_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_q[wr_ptr_q]    <= push_pc_i;
      taken_q[wr_ptr_q] <= push_taken_i;
      meta_q[wr_ptr_q]  <= push_metadata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      occ_q <= occ_q + 1'b1;
      else if (do_pop && !do_push) occ_q <= occ_q - 1'b1;
    end
  end

  // Only valid and mispredict pulse; the payload fields hold their last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q <= '0;
      mis_q <= 1'b0;
    end else begin
      upd_q.valid <= do_pop;
      mis_q       <= do_pop && (resolve_taken_i != taken_q[rd_ptr_q]);
      if (do_pop) begin
        upd_q.pc       <= pc_q[rd_ptr_q];
        upd_q.taken    <= resolve_taken_i;
        upd_q.metadata <= meta_q[rd_ptr_q];
      end
    end
  end

`ifdef MBP_UQ_STATS_EN
  logic [CNT_W-1:0] stat_upd_q, stat_mis_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_q.valid && (stat_upd_q != '1)) stat_upd_q <= stat_upd_q + 1'b1;
      if (mis_q && (stat_mis_q != '1))       stat_mis_q <= stat_mis_q + 1'b1;
    end
  end

  assign stat_updates_o     = stat_upd_q;
  assign stat_mispredicts_o = stat_mis_q;
`else
  assign stat_updates_o     = '0;
  assign stat_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_mbp_update_queue.sv
// Directed plus randomized bench for mbp_update_queue against a queue-based reference model.
`timescale 1ns/1ps

module tb_mbp_update_queue;
  import mbp_uq_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int VLEN  = build_config.VLEN;
  localparam int MW    = $bits(bp_metadata_t);

  logic               clk_i, rst_ni, flush_i;
  logic               push_valid_i, push_ready_o, push_taken_i;
  logic [VLEN-1:0]    push_pc_i;
  bp_metadata_t       push_metadata_i;
  logic               resolve_valid_i, resolve_taken_i;
  bht_update_t        bht_update_o;
  logic               mispredict_o, empty_o, full_o;
  logic [3:0]         occupancy_o;
  logic [CNT_W-1:0]   stat_updates_o, stat_mispredicts_o;

  mbp_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_pc_i(push_pc_i), .push_taken_i(push_taken_i), .push_metadata_i(push_metadata_i),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .bht_update_o(bht_update_o), .mispredict_o(mispredict_o),
    .occupancy_o(occupancy_o), .empty_o(empty_o), .full_o(full_o),
    .stat_updates_o(stat_updates_o), .stat_mispredicts_o(stat_mispredicts_o)
  );

  // clock/reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [VLEN-1:0] pc;
    logic            taken;
    bp_metadata_t    meta;
  } entry_t;

  entry_t       model_q[$];
  bht_update_t  exp_upd;
  logic         exp_mis;
  int unsigned  exp_stat_upd, exp_stat_mis;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_upd      = '0;
    exp_mis      = 1'b0;
    exp_stat_upd = 0;
    exp_stat_mis = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".bht_update"}, bht_update_o, exp_upd);
    check({tag, ".mispredict"}, mispredict_o, exp_mis);
    check({tag, ".occupancy"}, occupancy_o, model_q.size());
    check({tag, ".empty"}, empty_o, model_q.size() == 0);
    check({tag, ".full"}, full_o, model_q.size() == DEPTH);
    check({tag, ".push_ready"}, push_ready_o, model_q.size() < DEPTH);
    check({tag, ".stat_updates"}, stat_updates_o, exp_stat_upd);
    check({tag, ".stat_mispredicts"}, stat_mispredicts_o, exp_stat_mis);
  endtask

  // driver task: one clock cycle of stimulus, model step, and output check
  task automatic cycle(input string tag, input logic pv, input logic [VLEN-1:0] pc,
                       input logic pt, input bp_metadata_t md, input logic rv,
                       input logic rt, input logic fl);
    bit     ready;
    entry_t e;
    push_valid_i    = pv;
    push_pc_i       = pc;
    push_taken_i    = pt;
    push_metadata_i = md;
    resolve_valid_i = rv;
    resolve_taken_i = rt;
    flush_i         = fl;
    #1;
    ready = model_q.size() < DEPTH;
    check({tag, ".ready_pre"}, push_ready_o, ready);
    // counters follow the outputs that were visible during this cycle
    `ifdef MBP_UQ_STATS_EN
    if (exp_upd.valid) exp_stat_upd++;
    if (exp_mis) exp_stat_mis++;
    `endif
    if (rv && model_q.size() > 0) begin
      e = model_q.pop_front();
      exp_upd.valid    = 1'b1;
      exp_upd.pc       = e.pc;
      exp_upd.taken    = rt;
      exp_upd.metadata = e.meta;
      exp_mis          = (rt != e.taken);
    end else begin
      exp_upd.valid = 1'b0;
      exp_mis       = 1'b0;
    end
    if (fl) model_q.delete();
    else if (pv && ready) begin
      e.pc = pc; e.taken = pt; e.meta = md;
      model_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    check_outputs(tag);
  endtask

  function automatic bp_metadata_t rand_meta();
    logic [31:0] r;
    r = $urandom;
    return r[MW-1:0];
  endfunction

  function automatic logic [VLEN-1:0] rand_pc();
    logic [VLEN-1:0] p;
    p = {$urandom, $urandom};
    p[1:0] = 2'b00;
    return p;
  endfunction

  bp_metadata_t m0, m1, m2, mz;

  initial begin
    mz = '0;
    m0 = 24'h0A5_3C1;
    m1 = 24'h3F0_0E2;
    m2 = 24'h111_7F5;
    rst_ni = 1'b0; flush_i = 1'b0; push_valid_i = 1'b0; push_pc_i = '0;
    push_taken_i = 1'b0; push_metadata_i = '0; resolve_valid_i = 1'b0; resolve_taken_i = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_outputs("post_reset");

    // three pushes then three taken resolves
    cycle("t1_push0", 1, 64'h100, 1, m0, 0, 0, 0);
    cycle("t1_push1", 1, 64'h104, 0, m1, 0, 0, 0);
    cycle("t1_push2", 1, 64'h108, 1, m2, 0, 0, 0);
    cycle("t2_res0", 0, '0, 0, mz, 1, 1, 0);
    cycle("t2_res1", 0, '0, 0, mz, 1, 1, 0);
    cycle("t2_res2", 0, '0, 0, mz, 1, 1, 0);
    cycle("t2_idle", 0, '0, 0, mz, 0, 0, 0);
    cycle("t2_idle2", 0, '0, 0, mz, 0, 0, 0);
    check("t2_stat_updates", stat_updates_o, exp_stat_upd);

    // fill to DEPTH, held 9th push, pop frees slot next cycle, then drain
    for (int i = 0; i < DEPTH; i++)
      cycle("t3_fill", 1, 64'h1000 + 64'(i * 4), i[0], rand_meta(), 0, 0, 0);
    cycle("t3_held", 1, 64'h2000, 1, m1, 0, 0, 0);
    cycle("t3_held_res", 1, 64'h2000, 1, m1, 1, 0, 0);
    cycle("t3_wrap_push", 1, 64'h2000, 1, m1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cycle("t3_drain", 0, '0, 0, mz, 1, 1'($urandom_range(0, 1)), 0);
    cycle("t3_empty_res", 0, '0, 0, mz, 1, 1, 0);

    // resolve on empty with a simultaneous push
    cycle("t4_empty_push", 1, 64'h3000, 0, m2, 1, 1, 0);
    cycle("t4_res", 0, '0, 0, mz, 1, 1, 0);

    // flush with resolve and push in the same cycle
    for (int i = 0; i < 4; i++)
      cycle("t5_fill", 1, 64'h4000 + 64'(i * 4), 1, rand_meta(), 0, 0, 0);
    cycle("t5_flush", 1, 64'h5000, 0, m0, 1, 0, 1);
    cycle("t5_after", 0, '0, 0, mz, 1, 1, 0);

    // asynchronous reset while an update is on the output
    cycle("t6_push", 1, 64'h6000, 0, m1, 0, 0, 0);
    cycle("t6_push2", 1, 64'h6004, 1, m2, 0, 0, 0);
    cycle("t6_res", 0, '0, 0, mz, 1, 1, 0);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check("t6_async_valid", bht_update_o.valid, 1'b0);
    check_outputs("t6_async");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 9) < 7), rand_pc(), 1'($urandom_range(0, 1)), rand_meta(),
            ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    for (int i = 0; i < DEPTH + 1; i++)
      cycle("rand_drain", 0, '0, 0, mz, 1, 1'($urandom_range(0, 1)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
